// File: rtl/vector_issue_pkg.sv
// Packet layout shared by the scalar-side issuer and the vector dispatch decode.
package vector_issue_pkg;

    localparam int unsigned INSTR_LSB = 0;
    localparam int unsigned INSTR_W   = 32;
    localparam int unsigned RS1_LSB   = 32;
    localparam int unsigned RS1_W     = 32;
    localparam int unsigned RS2_LSB   = 64;
    localparam int unsigned RS2_W     = 32;
    localparam int unsigned PACKET_W  = INSTR_W + RS1_W + RS2_W;

    // Most-significant field first so the struct matches the flat bit layout.
    typedef struct packed {
        logic [RS2_W-1:0]   rs2;
        logic [RS1_W-1:0]   rs1;
        logic [INSTR_W-1:0] instr;
    } vec_packet_t;

endpackage

// File: rtl/issue_fifo.sv
// Packet storage with wrapping pointers and a separate occupancy counter.
module issue_fifo
    import vector_issue_pkg::*;
#(
    parameter int unsigned WIDTH = PACKET_W,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_valid,
    input  logic [WIDTH-1:0]           push_data,
    output logic                       push_ready,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_data,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_fire;
    logic             pop_fire;

    // Full is judged on current occupancy only, so a same-cycle pop never relieves it.
    assign push_ready = (occupancy != CNT_W'(DEPTH));
    assign push_fire  = push_valid && push_ready;
    assign pop_fire   = pop && (occupancy != CNT_W'(0));
    assign head_data  = mem[rd_ptr];

    // Storage write; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (push_fire) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy update.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (push_fire) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_fire) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_fire, pop_fire})
                2'b10:   occupancy <= occupancy + CNT_W'(1);
                2'b01:   occupancy <= occupancy - CNT_W'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

endmodule

// File: rtl/vector_issue_queue.sv
// Scalar-side issuer: queues committed vector packets, throttles on in-flight count.
module vector_issue_queue
    import vector_issue_pkg::*;
#(
    parameter int unsigned DATA_FROM_SCALAR = PACKET_W,
    parameter int unsigned QUEUE_DEPTH      = 4,
    parameter int unsigned MAX_OUTSTANDING  = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 push_valid,
    input  logic [DATA_FROM_SCALAR-1:0]          push_data,
    output logic                                 push_ready,
    output logic                                 valid_fifo,
    output logic [DATA_FROM_SCALAR-1:0]          instruction,
    input  logic                                 ready,
    input  logic                                 vec_done,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0]     occupancy,
    output logic                                 vector_idle,
    output logic                                 done_underflow
);

    localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned OCC_W = $clog2(QUEUE_DEPTH + 1);

    logic issue;

    issue_fifo #(
        .WIDTH (DATA_FROM_SCALAR),
        .DEPTH (QUEUE_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_valid (push_valid),
        .push_data  (push_data),
        .push_ready (push_ready),
        .pop        (issue),
        .head_data  (instruction),
        .occupancy  (occupancy)
    );

    // Issue is offered only when data is queued and the in-flight limit is not reached.
    assign valid_fifo  = (occupancy != OCC_W'(0)) && (outstanding != OUT_W'(MAX_OUTSTANDING));
    assign issue       = valid_fifo && ready;
    assign vector_idle = (occupancy == OCC_W'(0)) && (outstanding == OUT_W'(0));

    // In-flight counter with sticky underflow detection on a stray completion.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            outstanding    <= '0;
            done_underflow <= 1'b0;
        end else begin
            if (issue && !vec_done) begin
                outstanding <= outstanding + OUT_W'(1);
            end else if (!issue && vec_done) begin
                if (outstanding == OUT_W'(0)) begin
                    done_underflow <= 1'b1;
                end else begin
                    outstanding <= outstanding - OUT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_vector_issue_queue.sv
// Self-checking bench for vector_issue_queue with a packet scoreboard.
module tb_vector_issue_queue;
    import vector_issue_pkg::*;

    localparam int unsigned DW = PACKET_W;
    localparam int unsigned QD = 4;
    localparam int unsigned MO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          push_valid;
    logic [DW-1:0] push_data;
    logic          push_ready;
    logic          valid_fifo;
    logic [DW-1:0] instruction;
    logic          ready;
    logic          vec_done;
    logic [3:0]    outstanding;
    logic [2:0]    occupancy;
    logic          vector_idle;
    logic          done_underflow;

    int n_cmp = 0;
    int n_bad = 0;

    vector_issue_queue #(
        .DATA_FROM_SCALAR (DW),
        .QUEUE_DEPTH      (QD),
        .MAX_OUTSTANDING  (MO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .push_valid     (push_valid),
        .push_data      (push_data),
        .push_ready     (push_ready),
        .valid_fifo     (valid_fifo),
        .instruction    (instruction),
        .ready          (ready),
        .vec_done       (vec_done),
        .outstanding    (outstanding),
        .occupancy      (occupancy),
        .vector_idle    (vector_idle),
        .done_underflow (done_underflow)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] pkt(input int unsigned k);
        return {32'h2000_0000 | k, 32'h1000_0000 | k, k};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model and scoreboard, evaluated on every falling edge.
    task automatic monitor();
        int            m_occ = 0;
        int            m_out = 0;
        bit            m_uf  = 1'b0;
        logic [DW-1:0] sb[$];
        logic [DW-1:0] exp;
        bit            ev;
        bit            pa;
        bit            is;
        forever begin
            @(negedge clk);
            if (!rst) begin
                m_occ = 0;
                m_out = 0;
                m_uf  = 1'b0;
                sb.delete();
            end
            ev = (m_occ != 0) && (m_out != int'(MO));
            n_cmp++;
            if (occupancy !== 3'(m_occ)) begin
                n_bad++;
                $display("FAIL occupancy: got %0d expected %0d at %0t", occupancy, m_occ, $time);
            end
            n_cmp++;
            if (outstanding !== 4'(m_out)) begin
                n_bad++;
                $display("FAIL outstanding: got %0d expected %0d at %0t", outstanding, m_out, $time);
            end
            n_cmp++;
            if (valid_fifo !== ev) begin
                n_bad++;
                $display("FAIL valid_fifo: got %b expected %b at %0t", valid_fifo, ev, $time);
            end
            n_cmp++;
            if (push_ready !== (m_occ != int'(QD))) begin
                n_bad++;
                $display("FAIL push_ready: got %b expected %b at %0t", push_ready, (m_occ != int'(QD)), $time);
            end
            n_cmp++;
            if (vector_idle !== (m_occ == 0 && m_out == 0)) begin
                n_bad++;
                $display("FAIL vector_idle: got %b expected %b at %0t", vector_idle, (m_occ == 0 && m_out == 0), $time);
            end
            n_cmp++;
            if (done_underflow !== m_uf) begin
                n_bad++;
                $display("FAIL done_underflow: got %b expected %b at %0t", done_underflow, m_uf, $time);
            end
            if (rst) begin
                is = ev && (ready === 1'b1);
                pa = (push_valid === 1'b1) && (m_occ != int'(QD));
                if (is) begin
                    n_cmp++;
                    if (sb.size() == 0) begin
                        n_bad++;
                        $display("FAIL instruction: got %h expected nothing (empty scoreboard) at %0t", instruction, $time);
                    end else begin
                        exp = sb.pop_front();
                        if (instruction !== exp) begin
                            n_bad++;
                            $display("FAIL instruction: got %h expected %h at %0t", instruction, exp, $time);
                        end
                    end
                end
                if (pa) sb.push_back(push_data);
                m_occ = m_occ + int'(pa) - int'(is);
                if (is && !vec_done) begin
                    m_out++;
                end else if (!is && vec_done) begin
                    if (m_out == 0) m_uf = 1'b1;
                    else m_out--;
                end
            end
        end
    endtask

    // Offer packets first..first+count-1, each held until accepted, within a cycle budget.
    task automatic push_seq(input int unsigned first, input int count, input int budget);
        int i   = 0;
        int cyc = 0;
        bit acc;
        push_valid = 1'b1;
        push_data  = pkt(first);
        while (i < count && cyc < budget) begin
            acc = push_ready;
            step();
            cyc++;
            if (acc) begin
                i++;
                push_data = pkt(first + i);
            end
        end
        push_valid = 1'b0;
        n_cmp++;
        if (i != count) begin
            n_bad++;
            $display("FAIL push_timeout: got %0d accepted expected %0d", i, count);
        end
    endtask

    // Retire everything in flight and empty the queue.
    task automatic drain();
        ready      = 1'b1;
        push_valid = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (vector_idle) break;
            vec_done = (outstanding != 4'd0);
            step();
        end
        vec_done = 1'b0;
        ready    = 1'b0;
        n_cmp++;
        if (vector_idle !== 1'b1) begin
            n_bad++;
            $display("FAIL drain_timeout: got idle=%b expected 1", vector_idle);
        end
    endtask

    task automatic test_reset();
        rst        = 1'b0;
        push_valid = 1'b0;
        push_data  = '0;
        ready      = 1'b0;
        vec_done   = 1'b0;
        #3;
        n_cmp++; if (push_ready !== 1'b1)     begin n_bad++; $display("FAIL reset_push_ready: got %b expected 1", push_ready); end
        n_cmp++; if (valid_fifo !== 1'b0)     begin n_bad++; $display("FAIL reset_valid_fifo: got %b expected 0", valid_fifo); end
        n_cmp++; if (vector_idle !== 1'b1)    begin n_bad++; $display("FAIL reset_idle: got %b expected 1", vector_idle); end
        n_cmp++; if (done_underflow !== 1'b0) begin n_bad++; $display("FAIL reset_underflow: got %b expected 0", done_underflow); end
        n_cmp++; if (occupancy !== 3'd0)      begin n_bad++; $display("FAIL reset_occupancy: got %0d expected 0", occupancy); end
        n_cmp++; if (outstanding !== 4'd0)    begin n_bad++; $display("FAIL reset_outstanding: got %0d expected 0", outstanding); end
        step();
        step();
        rst = 1'b1;
        step();
    endtask

    task automatic test_basic();
        int unsigned ks[3] = '{32'hA, 32'hB, 32'hC};
        ready = 1'b1;
        foreach (ks[i]) begin
            push_valid = 1'b1;
            push_data  = pkt(ks[i]);
            step();
            n_cmp++;
            if (valid_fifo !== 1'b1 || instruction !== pkt(ks[i])) begin
                n_bad++;
                $display("FAIL basic_latency: got v=%b %h expected v=1 %h", valid_fifo, instruction, pkt(ks[i]));
            end
        end
        push_valid = 1'b0;
        step();
        n_cmp++; if (outstanding !== 4'd3)  begin n_bad++; $display("FAIL basic_outstanding: got %0d expected 3", outstanding); end
        n_cmp++; if (vector_idle !== 1'b0)  begin n_bad++; $display("FAIL basic_idle: got %b expected 0", vector_idle); end
        drain();
    endtask

    task automatic test_fill();
        ready = 1'b0;
        push_seq(32'h10, 4, 10);
        n_cmp++; if (occupancy !== 3'd4)           begin n_bad++; $display("FAIL fill_occupancy: got %0d expected 4", occupancy); end
        n_cmp++; if (push_ready !== 1'b0)          begin n_bad++; $display("FAIL fill_push_ready: got %b expected 0", push_ready); end
        n_cmp++; if (instruction !== pkt(32'h10))  begin n_bad++; $display("FAIL fill_head: got %h expected %h", instruction, pkt(32'h10)); end
        push_valid = 1'b1;
        push_data  = pkt(32'h14);
        step();
        step();
        n_cmp++; if (occupancy !== 3'd4)           begin n_bad++; $display("FAIL fill_held: got %0d expected 4", occupancy); end
        ready = 1'b1;
        push_seq(32'h14, 1, 10);
        for (int c = 0; c < 5; c++) step();
        n_cmp++; if (occupancy !== 3'd0)           begin n_bad++; $display("FAIL fill_empty: got %0d expected 0", occupancy); end
        n_cmp++; if (outstanding !== 4'd5)         begin n_bad++; $display("FAIL fill_outstanding: got %0d expected 5", outstanding); end
        drain();
    endtask

    task automatic test_throttle();
        ready = 1'b1;
        push_seq(32'h20, 10, 40);
        for (int c = 0; c < 3; c++) step();
        n_cmp++; if (outstanding !== 4'd8)         begin n_bad++; $display("FAIL thr_outstanding: got %0d expected 8", outstanding); end
        n_cmp++; if (valid_fifo !== 1'b0)          begin n_bad++; $display("FAIL thr_valid: got %b expected 0", valid_fifo); end
        n_cmp++; if (occupancy !== 3'd2)           begin n_bad++; $display("FAIL thr_occupancy: got %0d expected 2", occupancy); end
        vec_done = 1'b1;
        step();
        vec_done = 1'b0;
        n_cmp++; if (valid_fifo !== 1'b1)          begin n_bad++; $display("FAIL thr_release: got %b expected 1", valid_fifo); end
        n_cmp++; if (instruction !== pkt(32'h28))  begin n_bad++; $display("FAIL thr_head: got %h expected %h", instruction, pkt(32'h28)); end
        step();
        n_cmp++; if (outstanding !== 4'd8)         begin n_bad++; $display("FAIL thr_reissue: got %0d expected 8", outstanding); end
        n_cmp++; if (valid_fifo !== 1'b0 || occupancy !== 3'd1) begin
            n_bad++; $display("FAIL thr_one_more: got v=%b occ=%0d expected v=0 occ=1", valid_fifo, occupancy);
        end
        drain();
    endtask

    task automatic test_simultaneous();
        ready = 1'b1;
        push_seq(32'h30, 3, 10);
        step();
        ready = 1'b0;
        push_seq(32'h33, 2, 10);
        n_cmp++; if (outstanding !== 4'd3 || occupancy !== 3'd2) begin
            n_bad++; $display("FAIL sim_setup: got out=%0d occ=%0d expected out=3 occ=2", outstanding, occupancy);
        end
        ready      = 1'b1;
        vec_done   = 1'b1;
        push_valid = 1'b1;
        push_data  = pkt(32'h35);
        step();
        ready      = 1'b0;
        vec_done   = 1'b0;
        push_valid = 1'b0;
        n_cmp++; if (outstanding !== 4'd3)         begin n_bad++; $display("FAIL sim_outstanding: got %0d expected 3", outstanding); end
        n_cmp++; if (occupancy !== 3'd2)           begin n_bad++; $display("FAIL sim_occupancy: got %0d expected 2", occupancy); end
        n_cmp++; if (instruction !== pkt(32'h34))  begin n_bad++; $display("FAIL sim_head: got %h expected %h", instruction, pkt(32'h34)); end
        drain();
    endtask

    task automatic test_underflow();
        ready    = 1'b0;
        vec_done = 1'b1;
        step();
        vec_done = 1'b0;
        n_cmp++; if (outstanding !== 4'd0)         begin n_bad++; $display("FAIL uf_count: got %0d expected 0", outstanding); end
        n_cmp++; if (done_underflow !== 1'b1)      begin n_bad++; $display("FAIL uf_flag: got %b expected 1", done_underflow); end
        for (int c = 0; c < 3; c++) step();
        n_cmp++; if (done_underflow !== 1'b1)      begin n_bad++; $display("FAIL uf_sticky: got %b expected 1", done_underflow); end
    endtask

    task automatic test_reset_mid();
        ready = 1'b1;
        push_seq(32'h40, 5, 20);
        step();
        ready = 1'b0;
        push_seq(32'h45, 3, 10);
        n_cmp++; if (outstanding !== 4'd5 || occupancy !== 3'd3) begin
            n_bad++; $display("FAIL mid_setup: got out=%0d occ=%0d expected out=5 occ=3", outstanding, occupancy);
        end
        #2;
        rst = 1'b0;
        #1;
        n_cmp++; if (occupancy !== 3'd0)           begin n_bad++; $display("FAIL mid_occupancy: got %0d expected 0", occupancy); end
        n_cmp++; if (outstanding !== 4'd0)         begin n_bad++; $display("FAIL mid_outstanding: got %0d expected 0", outstanding); end
        n_cmp++; if (valid_fifo !== 1'b0)          begin n_bad++; $display("FAIL mid_valid: got %b expected 0", valid_fifo); end
        n_cmp++; if (push_ready !== 1'b1)          begin n_bad++; $display("FAIL mid_push_ready: got %b expected 1", push_ready); end
        n_cmp++; if (vector_idle !== 1'b1)         begin n_bad++; $display("FAIL mid_idle: got %b expected 1", vector_idle); end
        n_cmp++; if (done_underflow !== 1'b0)      begin n_bad++; $display("FAIL mid_underflow: got %b expected 0", done_underflow); end
        step();
        rst = 1'b1;
        step();
        step();
        n_cmp++; if (vector_idle !== 1'b1)         begin n_bad++; $display("FAIL mid_after: got %b expected 1", vector_idle); end
    endtask

    initial begin
        rst        = 1'b0;
        push_valid = 1'b0;
        push_data  = '0;
        ready      = 1'b0;
        vec_done   = 1'b0;
        fork
            monitor();
        join_none
        test_reset();
        test_basic();
        test_fill();
        test_throttle();
        test_simultaneous();
        test_underflow();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
